// File: rtl/alu_ram_block.sv
// rtl/alu_ram_block.sv - accumulator CPU datapath: 32-bit combinational ALU plus single-port RAM on a tristate bus
module alu_ram_block #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int ALU_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ALU_WIDTH-1:0]  A,
    input  logic [ALU_WIDTH-1:0]  B,
    input  logic [2:0]            ALU_Sel,
    output logic [ALU_WIDTH-1:0]  ALU_Out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  mem_wr;
    logic                  bus_drive;

    assign mem_wr    = cs_input && we;
    assign bus_drive = cs_input && oe && !we && !rst;

    // The array is deliberately left out of reset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[addr] <= data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (cs_input && !we) begin
            rd_data_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign data = bus_drive ? rd_data_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            3'b000: ALU_Out = A & B;
            3'b001: ALU_Out = A + B;
            3'b010: ALU_Out = A - B;
            3'b011: ALU_Out = A ^ B;
            3'b100: ALU_Out = A | B;
            3'b101: ALU_Out = ~A;
            3'b110: ALU_Out = A << 1;
            3'b111: ALU_Out = A >> 1;
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_ram_block.sv
// tb/tb_alu_ram_block.sv - scoreboard bench for alu_ram_block: RAM bus traffic and ALU vectors against a reference model
module tb_alu_ram_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] addr = '0;
    wire  [15:0] data;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic        oe = 1'b0;
    logic [31:0] a_op = '0;
    logic [31:0] b_op = '0;
    logic [2:0]  sel = '0;
    logic [31:0] alu_out;

    logic        tb_en = 1'b0;
    logic [15:0] tb_val = '0;

    logic [15:0] bus_q [$];
    logic [31:0] alu_q [$];
    logic [15:0] model_mem [int];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Undriven bus reads as all ones, so a released bus is observable in 2-state and 4-state simulators alike.
    assign data = tb_en ? tb_val : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (data[i]);
    end

    alu_ram_block #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .ALU_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data),
        .cs_input(cs), .we(we), .oe(oe),
        .A(a_op), .B(b_op), .ALU_Sel(sel), .ALU_Out(alu_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s);
        longint unsigned xa, ya, m, r;
        xa = longint'(x);
        ya = longint'(y);
        m  = 64'h1_0000_0000;
        case (s)
            3'd0: r = xa & ya;
            3'd1: r = (xa + ya) % m;
            3'd2: r = (xa + m - ya) % m;
            3'd3: r = xa ^ ya;
            3'd4: r = xa | ya;
            3'd5: r = (m - 1) - xa;
            3'd6: r = (xa * 2) % m;
            default: r = xa / 2;
        endcase
        return r[31:0];
    endfunction

    // Monitor: whenever the bus should be driven by the RAM, pop and compare; otherwise expect a released bus.
    always @(negedge clk) begin
        if (!tb_en) begin
            if (!rst && cs && oe && !we) begin
                if (bus_q.size() == 0) check("bus_underflow", 32'd1, 32'd0);
                else check("bus_read", {16'h0, data}, {16'h0, bus_q.pop_front()});
            end else begin
                check("bus_hiz", {16'h0, data}, 32'h0000FFFF);
            end
        end
        if (alu_q.size() > 0) check("alu", alu_out, alu_q.pop_front());
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic ram_write(input logic [13:0] a, input logic [15:0] v, input logic oe_v, input logic drive);
        addr = a; cs = 1'b1; we = 1'b1; oe = oe_v;
        tb_en = drive; tb_val = v;
        model_mem[int'(a)] = drive ? v : 16'hFFFF;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0; oe = 1'b0; tb_en = 1'b0;
    endtask

    task automatic ram_read(input logic [13:0] a);
        addr = a; cs = 1'b1; we = 1'b0; oe = 1'b0;
        @(posedge clk); #1;
        oe = 1'b1;
        bus_q.push_back(model_mem[int'(a)]);
        @(posedge clk); #1;
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic alu_vec(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s, input logic [31:0] exp);
        a_op = x; b_op = y; sel = s;
        alu_q.push_back(exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] wide_addr;
        logic [13:0] rnd_addr [$];
        logic [31:0] x, y;
        logic [2:0]  s;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        ram_write(14'h100, 16'h011E, 1'b0, 1'b1);
        ram_write(14'h102, 16'h0120, 1'b1, 1'b1);
        ram_read(14'h100);
        ram_read(14'h102);

        x = 32'h1800011C;
        ram_write(14'h104, x[15:0], 1'b0, 1'b1);
        wide_addr = 15'h4104;
        ram_read(wide_addr[13:0]);
        ram_write(wide_addr[13:0], 16'h5A3C, 1'b0, 1'b1);
        ram_read(14'h104);

        addr = 14'h102; cs = 1'b0; we = 1'b0; oe = 1'b1;
        @(posedge clk); #1;
        oe = 1'b0;
        ram_write(14'h3FFF, 16'h0000, 1'b1, 1'b0);
        ram_read(14'h3FFF);

        addr = 14'h100; cs = 1'b1; we = 1'b0; oe = 1'b0;
        @(posedge clk); #1;
        oe = 1'b1;
        bus_q.push_back(16'h011E);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_q.push_back(16'h0000);
        @(posedge clk); #1;
        bus_q.push_back(16'h011E);
        @(posedge clk); #1;
        cs = 1'b0; oe = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [13:0] ra;
            ra = 14'($urandom_range(16'h0200, 16'h3F00));
            rnd_addr.push_back(ra);
            ram_write(ra, 16'($urandom_range(0, 16'hFFFE)), 1'($urandom_range(0, 1)), 1'b1);
        end
        rnd_addr.shuffle();
        foreach (rnd_addr[i]) ram_read(rnd_addr[i]);

        alu_vec(32'd5, 32'd7, 3'b001, 32'd12);
        alu_vec(32'd5, 32'd7, 3'b010, 32'hFFFFFFFE);
        alu_vec(32'hFFFFFFFF, 32'd1, 3'b001, 32'h0);
        alu_vec(32'h0F0F00F0, 32'h00FF0FF0, 3'b000, 32'h000F00F0);
        alu_vec(32'h0F0F00F0, 32'h00FF0FF0, 3'b100, 32'h0FFF0FF0);
        alu_vec(32'h0F0F00F0, 32'h00FF0FF0, 3'b011, 32'h0FF00F00);
        alu_vec(32'h0F0F00F0, 32'h00FF0FF0, 3'b101, 32'hF0F0FF0F);
        alu_vec(32'h80000001, 32'h0, 3'b110, 32'h00000002);
        alu_vec(32'h80000001, 32'h0, 3'b111, 32'h40000000);
        for (int i = 0; i < 40; i++) begin
            x = $urandom; y = $urandom; s = 3'($urandom_range(0, 7));
            alu_vec(x, y, s, alu_model(x, y, s));
        end

        repeat (3) @(posedge clk);
        #1;
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("alu_queue_drained", 32'(alu_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ram_block.md
Name: alu_ram_block

Overview:
- Combined datapath block for the accumulator CPU.
- Contains a 32-bit combinational ALU and a single-port synchronous RAM on a shared bidirectional data bus.
- The CPU control sequencer drives address/cs/we/oe and ALU operands, and captures bus read data and ALU results into its registers (MBR, IR, AC).

Parameters:
- ADDR_WIDTH, 14, RAM address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, RAM word and data-bus width.
- ALU_WIDTH, 32, ALU operand/result width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- addr  input  ADDR_WIDTH  RAM word address.
- data  inout  DATA_WIDTH  bidirectional RAM data bus.
- cs_input  input  1  RAM chip select, active-high.
- we  input  1  RAM write enable, active-high.
- oe  input  1  RAM output enable, active-high.
- A  input  ALU_WIDTH  ALU operand A.
- B  input  ALU_WIDTH  ALU operand B.
- ALU_Sel  input  3  ALU operation select.
- ALU_Out  output  ALU_WIDTH  ALU result.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high: rst=1 immediately clears the internal read-data register to 0 and tristates data.
  - Memory array contents are not reset.
- RAM write:
  - On a rising clk edge with cs_input=1, we=1, mem[addr] <= data.
  - Write data is whatever is on the bus at the edge; the external driver must drive data while we=1.
- RAM read:
  - On a rising clk edge with cs_input=1, we=0, the read register <= mem[addr].
  - Latency is one cycle: a word addressed before edge N is on data after edge N.
  - The read register holds its value when cs_input=0 or we=1.
- Bus drive:
  - data is driven with the read register only when cs_input=1, oe=1 and we=0.
  - Otherwise data is high-Z, including during reset.
  - we=1 with oe=1: no drive (write wins, no contention).
- Address wrap: addr is used modulo depth; no out-of-range behaviour.
- Uninitialised words read as X in simulation; no requirement on their value.
- ALU (purely combinational, zero latency; results modulo 2**ALU_WIDTH, no flags):
  - 000: A & B
  - 001: A + B (carry discarded)
  - 010: A - B (two's-complement, borrow discarded)
  - 011: A ^ B
  - 100: A | B
  - 101: ~A
  - 110: A << 1 (logical)
  - 111: A >> 1 (logical)
- ALU_Out is unaffected by rst and clk.

Test Plan:
- Reset:
  - Assert rst mid-cycle with cs_input=1, oe=1, we=0 -> data goes high-Z immediately.
  - After release and one read cycle of a pre-written address, data shows the stored word.
- Write/readback:
  - Write 0x011E to 0x100 and 0x0120 to 0x102 (cs_input=1, we=1, bus driven).
  - Then read 0x100 and 0x102 with we=0, oe=1 -> data = 0x011E and 0x0120, each one cycle after the address edge.
- Truncation/wrap:
  - Bus driver supplies low 16 bits of 0x1800011C at address 0x104 -> readback 0x011C.
  - Address 0x4104 with ADDR_WIDTH=14 aliases 0x0104.
- Bus control:
  - cs_input=0 or oe=0 during a read -> data high-Z.
  - we=1, oe=1 -> high-Z, and the write completes.
- ALU arithmetic:
  - A=5, B=7: sel 001 -> 12; sel 010 -> 0xFFFFFFFE.
  - A=0xFFFFFFFF, B=1: sel 001 -> 0.
- ALU logic:
  - A=0x0F0F00F0, B=0x00FF0FF0: sel 000 -> 0x000F00F0; sel 100 -> 0x0FFF0FF0; sel 011 -> 0x0FF00F00; sel 101 -> 0xF0F0FF0F.
  - A=0x80000001: sel 110 -> 0x00000002; sel 111 -> 0x40000000.
